imem_resp: RTL and testbench
============================

IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, read wait states per fetch, legal range 0..7.
REQ-002 Parameter IW, default 9, instruction word width.
REQ-003 Parameter DEPTH, default 256, instruction words; address width fixed at 8.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  fetch request from the program counter, sampled only in IDLE or RESP.
REQ-007 addr  input  8  fetch address, captured on request acceptance.
REQ-008 flush  input  1  cancel in-flight fetch (taken branch or halt).
REQ-009 ld_we  input  1  program-load write strobe.
REQ-010 ld_addr  input  8  program-load write address.
REQ-011 ld_data  input  IW  program-load write data.
REQ-012 valid  output  1  instr holds the requested word; one-cycle pulse per fetch.
REQ-013 instr  output  IW  registered instruction word.
REQ-014 busy  output  1  stall to program counter; high exactly while state is WAIT.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; state register plus 3-bit down-counter cnt.
REQ-016 Acceptance: req=1 in IDLE or RESP with flush=0 latches addr into areg.
REQ-017 On acceptance: WAIT_CYCLES>0 -> state WAIT, cnt<=WAIT_CYCLES; WAIT_CYCLES=0 -> state RESP.
REQ-018 WAIT: cnt decrements each cycle; when cnt==1, next state RESP; WAIT lasts exactly WAIT_CYCLES cycles.
REQ-019 On entry to RESP: instr<=mem[areg]; valid=1 for that RESP cycle only.
REQ-020 Latency: request accepted at edge N -> valid high in cycle N+1+WAIT_CYCLES.
REQ-021 RESP with req=0 -> IDLE; RESP with req=1 -> back-to-back acceptance per REQ-017, no idle bubble.
REQ-022 req in WAIT is ignored; the requester holds req until valid.
REQ-023 instr holds its last value when valid=0.
REQ-024 flush=1 in any state -> next state IDLE, cnt<=0, no valid pulse for the cancelled fetch; flush overrides a simultaneous req.
REQ-025 ld_we=1 writes ld_data to mem[ld_addr] in any state, including during WAIT.
REQ-026 Write and read of the same address on the same edge -> instr receives the old word (read-before-write).
REQ-027 Memory contents are not reset; every address is reachable, with no out-of-range case.

Reset
REQ-028 reset low asynchronously forces: state IDLE, cnt 0, areg 0, valid 0, instr 0, busy 0, cache tag invalid.
REQ-029 Reset asserted mid-fetch discards the fetch; no valid pulse after release until a new request.
REQ-030 The first request is accepted on the first rising edge with reset high.

Configuration
REQ-031 Macro IMEM_CACHE_EN defined: one-entry last-address cache (tag register plus tag-valid bit).
REQ-032 With IMEM_CACHE_EN: on each RESP, tag<=areg and tag-valid<=1.
REQ-033 With IMEM_CACHE_EN: an accepted request whose addr equals a valid tag goes directly to RESP (1-cycle latency), regardless of WAIT_CYCLES.
REQ-034 With IMEM_CACHE_EN: ld_we to the tag address or flush clears tag-valid.
REQ-035 Without IMEM_CACHE_EN: no tag logic; every fetch takes WAIT_CYCLES+1 cycles.

Verification
REQ-036 WAIT_CYCLES=2, mem[0x10]=0x1A5, req with addr=0x10 at edge 0 -> busy high in cycles 1-2, valid with instr=0x1A5 in cycle 3.
REQ-037 Back-to-back: req held with addr 0x00 then 0x01 -> valid pulses in cycles 3 and 6, instr=mem[0x00] then mem[0x01].
REQ-038 flush in cycle 2 of a fetch with simultaneous req=1 -> no valid pulse, state IDLE in cycle 3, busy low.
REQ-039 ld_we to 0x20 with data 0x0FF on the same edge the RESP read of 0x20 occurs -> instr=old value; a refetch returns 0x0FF.
REQ-040 IMEM_CACHE_EN, WAIT_CYCLES=3: fetch 0x05 twice -> second valid 1 cycle after acceptance; after ld_we to 0x05, a third fetch takes 4 cycles.
REQ-041 reset low during WAIT -> valid, busy, and instr equal 0 immediately, with no valid pulse after release.

Source files
------------

// File: rtl/imem_resp_if.sv
// Fetch and program-load bus between the program counter and imem_resp.
// The state signal mirrors the responder FSM so checkers can bind to it.
interface imem_resp_if #(
  parameter int IW = 9
);
  // Handshake: the master raises req with addr and holds both until it sees a
  // one-cycle valid pulse. It may present the next addr in that valid cycle to
  // chain fetches. busy is high while the word is being read, and flush cancels
  // any fetch that is in flight.
  logic          req;
  logic [7:0]    addr;
  logic          flush;
  logic          ld_we;
  logic [7:0]    ld_addr;
  logic [IW-1:0] ld_data;
  logic          valid;
  logic [IW-1:0] instr;
  logic          busy;
  logic [1:0]    state;

  modport master (
    output req, addr, flush, ld_we, ld_addr, ld_data,
    input  valid, instr, busy, state
  );

  modport slave (
    input  req, addr, flush, ld_we, ld_addr, ld_data,
    output valid, instr, busy, state
  );
endinterface

// File: rtl/imem_resp.sv
// Instruction memory responder: programmable wait states, flush and program load.
// Optional one-entry last-address cache enabled by defining IMEM_CACHE_EN.
module imem_resp #(
  parameter int WAIT_CYCLES = 2,
  parameter int IW          = 9,
  parameter int DEPTH       = 256
) (
  input  logic        clk,
  input  logic        reset,
  imem_resp_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [2:0] WC     = 3'(WAIT_CYCLES);

  logic [IW-1:0] mem [DEPTH];
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [2:0]    cnt;
  logic [7:0]    areg;
  logic [IW-1:0] instr_q;
  logic          accept;
  logic          hit;
  logic          direct;
  logic          wait_done;
  logic          load_instr;
  logic [7:0]    rd_addr;

  assign accept = bus.req && !bus.flush && (state == S_IDLE || state == S_RESP);

`ifdef IMEM_CACHE_EN
  logic [7:0] tag;
  logic       tag_v;

  assign hit = accept && tag_v && (bus.addr == tag);

  // The tag is refreshed in every RESP cycle; a write landing on that same
  // address in the same cycle must leave it invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag   <= 8'd0;
      tag_v <= 1'b0;
    end else if (state == S_RESP) begin
      tag   <= areg;
      tag_v <= !bus.flush && !(bus.ld_we && bus.ld_addr == areg);
    end else if (bus.flush || (bus.ld_we && bus.ld_addr == tag)) begin
      tag_v <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Going straight to RESP means areg is being written on the same edge, so
  // the read must take the incoming address.
  assign direct     = accept && (WAIT_CYCLES == 0 || hit);
  assign wait_done  = (state == S_WAIT) && (cnt <= 3'd1) && !bus.flush;
  assign load_instr = direct || wait_done;
  assign rd_addr    = direct ? bus.addr : areg;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = direct ? S_RESP : S_WAIT;
      S_WAIT: if (cnt <= 3'd1) state_nx = S_RESP;
      S_RESP: begin
        if (accept) state_nx = direct ? S_RESP : S_WAIT;
        else        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (bus.flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      areg    <= 8'd0;
      instr_q <= '0;
    end else begin
      state <= state_nx;
      if (bus.flush)             cnt <= 3'd0;
      else if (accept && !direct) cnt <= WC;
      else if (state == S_WAIT)  cnt <= cnt - 3'd1;
      if (accept)     areg    <= bus.addr;
      if (load_instr) instr_q <= mem[rd_addr];
    end
  end

  // Memory has no reset; a same-edge read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (bus.ld_we) mem[bus.ld_addr] <= bus.ld_data;
  end

  assign bus.valid = (state == S_RESP);
  assign bus.busy  = (state == S_WAIT);
  assign bus.instr = instr_q;
  assign bus.state = state;

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: latency, back-to-back, flush, read-before-write,
// reset behaviour, and the last-address cache when IMEM_CACHE_EN is defined.
`timescale 1ns/1ps
module tb_imem_resp;
`ifdef IMEM_CACHE_EN
  localparam int WC = 3;
`else
  localparam int WC = 2;
`endif
  localparam logic [1:0] S_IDLE = 2'd0;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  imem_resp_if #(.IW(9)) bus();
  imem_resp #(.WAIT_CYCLES(WC), .IW(9), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [8:0] d);
    bus.ld_we = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    tick();
    bus.ld_we = 1'b0;
  endtask

  // Raises req, returns cycles from acceptance edge to valid (99 on timeout).
  task automatic fetch_wait(input logic [7:0] a, output int n);
    bus.req = 1'b1; bus.addr = a; n = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.valid === 1'b1) begin n = i; break; end
    end
    bus.req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req = 1'b0; bus.addr = 8'd0; bus.flush = 1'b0;
    bus.ld_we = 1'b0; bus.ld_addr = 8'd0; bus.ld_data = 9'd0;
    #2;
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL rst_state got %0d want 0", bus.state); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.instr !== 9'd0) begin errors++; $display("FAIL rst_instr got %h want 0", bus.instr); end
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    bus.req = 1'b1; bus.addr = 8'h10;
    for (int c = 1; c <= WC + 1; c++) begin
      tick();
      if (c == 1) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL first_accept_busy got %b want 1", bus.busy); end
      end
      if (c == WC + 1) begin
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL first_accept_valid got %b want 1", bus.valid); end
      end
    end
    bus.req = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load(8'h10, 9'h1A5);
    bus.req = 1'b1; bus.addr = 8'h10;
    for (int c = 1; c <= WC + 1; c++) begin
      tick();
      checks++; if (bus.busy !== (c <= WC)) begin errors++; $display("FAIL basic_busy c%0d got %b want %b", c, bus.busy, (c <= WC)); end
      checks++; if (bus.valid !== (c == WC + 1)) begin errors++; $display("FAIL basic_valid c%0d got %b want %b", c, bus.valid, (c == WC + 1)); end
    end
    checks++; if (bus.instr !== 9'h1A5) begin errors++; $display("FAIL basic_instr got %h want 1a5", bus.instr); end
    bus.req = 1'b0;
    tick();
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL basic_idle got %0d want 0", bus.state); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", bus.valid); end
    checks++; if (bus.instr !== 9'h1A5) begin errors++; $display("FAIL basic_hold got %h want 1a5", bus.instr); end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    load(8'h00, 9'h055);
    load(8'h01, 9'h12C);
    bus.req = 1'b1; bus.addr = 8'h00;
    for (int c = 1; c <= 2 * (WC + 1); c++) begin
      tick();
      exp_v = (c == WC + 1) || (c == 2 * (WC + 1));
      checks++; if (bus.valid !== exp_v) begin errors++; $display("FAIL b2b_valid c%0d got %b want %b", c, bus.valid, exp_v); end
      if (c == WC + 2) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_nobubble got %b want 1", bus.busy); end
      end
      if (c == WC + 1) begin
        checks++; if (bus.instr !== 9'h055) begin errors++; $display("FAIL b2b_instr0 got %h want 055", bus.instr); end
        bus.addr = 8'h01;
      end
      if (c == 2 * (WC + 1)) begin
        checks++; if (bus.instr !== 9'h12C) begin errors++; $display("FAIL b2b_instr1 got %h want 12c", bus.instr); end
        bus.req = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_flush();
    bus.req = 1'b1; bus.addr = 8'h10;
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.req = 1'b0;
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL flush_state got %0d want 0", bus.state); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.valid); end
    for (int c = 0; c < WC + 2; c++) begin
      tick();
      checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL flush_nopulse c%0d got %b want 0", c, bus.valid); end
    end
  endtask

  task automatic test_rbw();
    int n;
    load(8'h20, 9'h0AA);
    bus.req = 1'b1; bus.addr = 8'h20;
    for (int c = 1; c <= WC; c++) tick();
    bus.ld_we = 1'b1; bus.ld_addr = 8'h20; bus.ld_data = 9'h0FF;
    tick();
    bus.ld_we = 1'b0;
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL rbw_valid got %b want 1", bus.valid); end
    checks++; if (bus.instr !== 9'h0AA) begin errors++; $display("FAIL rbw_old got %h want 0aa", bus.instr); end
    bus.req = 1'b0;
    tick();
    fetch_wait(8'h20, n);
    checks++; if (n == 99) begin errors++; $display("FAIL rbw_refetch_timeout got %0d want valid", n); end
    checks++; if (bus.instr !== 9'h0FF) begin errors++; $display("FAIL rbw_new got %h want 0ff", bus.instr); end
    tick();
  endtask

`ifdef IMEM_CACHE_EN
  task automatic test_cache();
    int n;
    load(8'h05, 9'h15B);
    fetch_wait(8'h05, n);
    checks++; if (n !== WC + 1) begin errors++; $display("FAIL cache_miss_lat got %0d want %0d", n, WC + 1); end
    tick();
    fetch_wait(8'h05, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL cache_hit_lat got %0d want 1", n); end
    checks++; if (bus.instr !== 9'h15B) begin errors++; $display("FAIL cache_hit_instr got %h want 15b", bus.instr); end
    tick();
    load(8'h05, 9'h0C3);
    fetch_wait(8'h05, n);
    checks++; if (n !== WC + 1) begin errors++; $display("FAIL cache_inval_lat got %0d want %0d", n, WC + 1); end
    checks++; if (bus.instr !== 9'h0C3) begin errors++; $display("FAIL cache_inval_instr got %h want 0c3", bus.instr); end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    bus.req = 1'b1; bus.addr = 8'h10;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    checks++; if (bus.instr !== 9'd0) begin errors++; $display("FAIL midrst_instr got %h want 0", bus.instr); end
    bus.req = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int c = 0; c < WC + 3; c++) begin
      tick();
      checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midrst_nopulse c%0d got %b want 0", c, bus.valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_rbw();
`ifdef IMEM_CACHE_EN
    test_cache();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
